// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode constants, decode helper and FSM encoding for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I_ARITH = 7'b0010011;
    localparam logic [6:0] OP_I_LD    = 7'b0000011;
    localparam logic [6:0] OP_I_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_J_JAL   = 7'b1101111;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_ctl;
        logic is_load;
    } hz_decode_t;

    // Scoreboard slot layout: {valid, rd, is_load}.
    function automatic int hz_slot_w(input int reg_aw);
        return reg_aw + 2;
    endfunction

    function automatic hz_decode_t hz_decode(input logic [6:0] opcode);
        hz_decode_t d;
        d = '0;
        case (opcode)
            OP_R:       begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1; end
            OP_I_ARITH: begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
            OP_I_LD:    begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_load = 1'b1; end
            OP_I_JALR:  begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_ctl = 1'b1; end
            OP_S:       begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            OP_B:       begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.is_ctl = 1'b1; end
            OP_J_JAL:   begin d.writes_rd = 1'b1; d.is_ctl = 1'b1; end
            OP_U_LUI:   d.writes_rd = 1'b1;
            OP_U_AUIPC: d.writes_rd = 1'b1;
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_slot_shift.sv
// hz_slot_shift: shift register of in-flight destination writes with per-slot source compares.
module hz_slot_shift
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int WB_DEPTH   = 3,
    parameter int FORWARD_EN = 0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_load_v,
    input  logic [REG_AW-1:0]   i_load_rd,
    input  logic                i_load_is_ld,
    input  logic [REG_AW-1:0]   i_rs1,
    input  logic [REG_AW-1:0]   i_rs2,
    output logic [WB_DEPTH-1:0] o_match_rs1,
    output logic [WB_DEPTH-1:0] o_match_rs2
);

    localparam int SLOT_W = hz_slot_w(REG_AW);

    logic [WB_DEPTH-1:0][SLOT_W-1:0] r_slot;
    logic [WB_DEPTH-1:0]             w_qual;

    // NOTE: only the valid bits matter after reset, but whole slots are cleared so rd never holds X.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slot <= '0;
        end else begin
            r_slot[0] <= {i_load_v, i_load_rd, i_load_is_ld};
            for (int k = 1; k < WB_DEPTH; k++) begin
                r_slot[k] <= r_slot[k-1];
            end
        end
    end

    // With forwarding only a load still sitting in slot 0 can hazard.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_qual      = '0;
        o_match_rs1 = '0;
        o_match_rs2 = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            w_qual[k] = r_slot[k][SLOT_W-1]
                      & ((FORWARD_EN == 0) | ((k == 0) & r_slot[k][0]));
            o_match_rs1[k] = w_qual[k] & (r_slot[k][SLOT_W-2:1] == i_rs1);
            o_match_rs2[k] = w_qual[k] & (r_slot[k][SLOT_W-2:1] == i_rs2);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: scoreboard-based data stalls, control-transfer stall FSM, stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int WB_DEPTH   = 3,
    parameter int FORWARD_EN = 0,
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_valid,
    input  logic [6:0]        i_opcode,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_br_resolved,
    input  logic              i_flush,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_bubble_ex,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    localparam logic [3:0] PEN_LOAD = 4'(BR_PENALTY - 1);

    hz_decode_t          w_dec;
    logic [WB_DEPTH-1:0] w_slot_rs1;
    logic [WB_DEPTH-1:0] w_slot_rs2;
    logic                w_match_rs1;
    logic                w_match_rs2;
    logic                w_stall_id;
    logic                w_stall_if;
    logic                w_issue;

    hz_state_e           r_state;
    logic [3:0]          r_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;

    assign w_dec = hz_decode(i_opcode);

    hz_slot_shift #(
        .REG_AW     (REG_AW),
        .WB_DEPTH   (WB_DEPTH),
        .FORWARD_EN (FORWARD_EN)
    ) u_slots (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load_v     (w_issue),
        .i_load_rd    (i_rd),
        .i_load_is_ld (w_dec.is_load),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .o_match_rs1  (w_slot_rs1),
        .o_match_rs2  (w_slot_rs2)
    );

    assign w_match_rs1 = (i_rs1 != '0) & w_dec.uses_rs1 & (|w_slot_rs1);
    assign w_match_rs2 = (i_rs2 != '0) & w_dec.uses_rs2 & (|w_slot_rs2);
    assign w_stall_id  = i_id_valid & !i_flush & (w_match_rs1 | w_match_rs2);
    assign w_stall_if  = ((r_state == HZ_IDLE) & i_id_valid & w_dec.is_ctl & !i_flush)
                       | (r_state == HZ_WAIT);

    // A held or frozen instruction must not enter the scoreboard twice; x0 is never tracked.
    assign w_issue = i_id_valid & !w_stall_id & !w_stall_if & !i_flush
                   & w_dec.writes_rd & (i_rd != '0);

    assign o_stall_id  = w_stall_id & !i_reset;
    assign o_stall_if  = w_stall_if & !i_reset;
    assign o_bubble_ex = i_reset | w_stall_id | i_flush | !i_id_valid;
    assign o_stall_cnt = r_stall_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= HZ_IDLE;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((w_stall_id | w_stall_if) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (i_flush) begin
                r_state <= HZ_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    HZ_IDLE: begin
                        if (i_id_valid & w_dec.is_ctl & !w_stall_id) begin
                            r_state <= HZ_WAIT;
                            r_cnt   <= PEN_LOAD;
                        end
                    end
                    HZ_WAIT: begin
                        if (i_br_resolved || (r_cnt == '0)) begin
                            r_state <= HZ_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= HZ_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
